// File: rtl/parity_fifo.sv
// Synchronous FIFO that appends a parity bit to each payload word at push time.
// The head word, with its parity bit, feeds a downstream parity checker.
module parity_fifo #(
   parameter int EVEN_ODD          = 0,
   parameter int SELECT_PARITY_BIT = 0,
   parameter int DATA_WIDTH        = 8,
   parameter int DEPTH             = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_WIDTH-1:0]    push_data,
   input  logic                     push_valid,
   output logic                     push_grant,
   output logic [DATA_WIDTH:0]      pop_data,
   output logic                     pop_valid,
   input  logic                     pop_grant,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH:0] r_mem [DEPTH];
   logic [AW:0]         r_wptr;
   logic [AW:0]         r_rptr;

   logic                w_push;
   logic                w_pop;
   logic                w_parity;
   logic [DATA_WIDTH:0] w_word;

   assign w_parity = (^push_data) ^ (EVEN_ODD != 0);
   assign w_word   = (SELECT_PARITY_BIT != 0) ? {w_parity, push_data}
                                              : {push_data, w_parity};

   // The extra pointer MSB is a lap bit that separates full from empty.
   assign full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign empty      = (r_wptr == r_rptr);
   assign count      = r_wptr - r_rptr;
   assign push_grant = !full;
   assign pop_valid  = !empty;
   assign pop_data   = r_mem[r_rptr[AW-1:0]];

   assign w_push = push_valid && push_grant;
   assign w_pop  = pop_valid && pop_grant;

   // NOTE: storage has no reset; entries are only observable once the pointers
   // mark them valid, so clearing them would add reset fan-out for nothing.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= w_word;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

endmodule

// File: tb/tb_parity_fifo.sv
// Randomized scoreboard bench for parity_fifo: a queue model of payloads
// predicts occupancy flags and the encoded head word of three parity variants.
module tb_parity_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] push_data;
   logic          push_valid;
   logic          pop_grant;

   logic          push_grant, pop_valid, full, empty;
   logic [DW:0]   pop_data;
   logic [CW-1:0] count;

   logic          pg_odd, pv_odd, full_odd, empty_odd;
   logic [DW:0]   pd_odd;
   logic [CW-1:0] cnt_odd;
   logic          pg_msb, pv_msb, full_msb, empty_msb;
   logic [DW:0]   pd_msb;
   logic [CW-1:0] cnt_msb;

   int n_vec = 0;
   int n_err = 0;
   logic [DW-1:0] model_q [$];

   always #5 clk = ~clk;

   parity_fifo #(.EVEN_ODD(0), .SELECT_PARITY_BIT(0), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .push_data(push_data), .push_valid(push_valid),
      .push_grant(push_grant), .pop_data(pop_data), .pop_valid(pop_valid),
      .pop_grant(pop_grant), .count(count), .full(full), .empty(empty));

   parity_fifo #(.EVEN_ODD(1), .SELECT_PARITY_BIT(0), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut_odd (
      .clk(clk), .rst_n(rst_n), .push_data(push_data), .push_valid(push_valid),
      .push_grant(pg_odd), .pop_data(pd_odd), .pop_valid(pv_odd),
      .pop_grant(pop_grant), .count(cnt_odd), .full(full_odd), .empty(empty_odd));

   parity_fifo #(.EVEN_ODD(0), .SELECT_PARITY_BIT(1), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut_msb (
      .clk(clk), .rst_n(rst_n), .push_data(push_data), .push_valid(push_valid),
      .push_grant(pg_msb), .pop_data(pd_msb), .pop_valid(pv_msb),
      .pop_grant(pop_grant), .count(cnt_msb), .full(full_msb), .empty(empty_msb));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Parity bit makes the total count of ones even (odd=0) or odd (odd=1).
   function automatic logic [DW:0] encode(input logic [DW-1:0] d, input bit odd, input bit msb);
      logic p;
      p = (($countones(d) % 2) == 1) ^ odd;
      return msb ? {p, d} : {d, p};
   endfunction

   // Monitor: compares on the falling edge, then advances the model to match
   // what the next rising edge will do with the inputs currently applied.
   always @(negedge clk) begin
      int occ;
      occ = model_q.size();
      check("count",      32'(count),      32'(occ));
      check("empty",      32'(empty),      32'(occ == 0));
      check("full",       32'(full),       32'(occ == DEPTH));
      check("push_grant", 32'(push_grant), 32'(occ != DEPTH));
      check("pop_valid",  32'(pop_valid),  32'(occ != 0));
      check("count_odd",  32'(cnt_odd),    32'(occ));
      check("count_msb",  32'(cnt_msb),    32'(occ));
      if (occ != 0) begin
         check("pop_data_even_lsb", 32'(pop_data), 32'(encode(model_q[0], 1'b0, 1'b0)));
         check("pop_data_odd_lsb",  32'(pd_odd),   32'(encode(model_q[0], 1'b1, 1'b0)));
         check("pop_data_even_msb", 32'(pd_msb),   32'(encode(model_q[0], 1'b0, 1'b1)));
      end
      if (!rst_n) begin
         model_q.delete();
      end else begin
         if (pop_grant && occ != 0) void'(model_q.pop_front());
         if (push_valid && occ != DEPTH) model_q.push_back(push_data);
      end
   end

   task automatic drive(input logic rst, input logic pv, input logic pg, input logic [DW-1:0] d);
      rst_n      = rst;
      push_valid = pv;
      pop_grant  = pg;
      push_data  = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset for two cycles with a push offered; nothing must be stored.
      drive(1'b0, 1'b1, 1'b0, DW'($urandom));
      drive(1'b0, 1'b1, 1'b1, DW'($urandom));

      // Parity encodings: A5 through all three variants, then 01.
      drive(1'b1, 1'b1, 1'b0, 8'hA5);
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 8'h01);
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);

      // Fill to DEPTH, ninth offer must be refused.
      for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 1'b1, 1'b0, DW'($urandom));
      // Pop while full with push offered, then the freed slot refills.
      drive(1'b1, 1'b1, 1'b1, DW'($urandom));
      drive(1'b1, 1'b1, 1'b0, DW'($urandom));
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 1'b0, 1'b1, 8'h00);

      // Stream 20 words across the pointer wrap with push and pop together.
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b1, DW'($urandom));
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);

      // Downstream stall: head must stay put for five cycles.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, DW'($urandom));
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 8'h00);

      // Random traffic with one mid-operation reset.
      for (int i = 0; i < 400; i++) begin
         drive((i != 150), 1'($urandom), 1'($urandom_range(0, 3) != 0), DW'($urandom));
      end
      for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 1'b0, 1'b1, 8'h00);

      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/parity_fifo.md
PARITY_FIFO -- requirements
Module: parity_fifo

Interface
REQ-001 SHALL have parameter EVEN_ODD, default 0: parity sense, 0 = even, 1 = odd.
REQ-002 SHALL have parameter SELECT_PARITY_BIT, default 0: parity bit position in stored word, 1 = MSB, 0 = LSB.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: payload width.
REQ-004 SHALL have parameter DEPTH, default 8: entry count; power of 2, >= 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port push_data, input, DATA_WIDTH bits: payload from producer.
REQ-008 SHALL have port push_valid, input, 1 bit: producer offers push_data.
REQ-009 SHALL have port push_grant, output, 1 bit: FIFO accepts push this cycle.
REQ-010 SHALL have port pop_data, output, DATA_WIDTH+1 bits: head word, parity plus payload, feeding the downstream parity checker data_in.
REQ-011 SHALL have port pop_valid, output, 1 bit: head word present; drives checker pop_valid_fifo.
REQ-012 SHALL have port pop_grant, input, 1 bit: consumer takes head; driven by checker pop_grant_fifo.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have ports full and empty, output, 1 bit each: occupancy == DEPTH and occupancy == 0.

Function
REQ-015 Parity bit p SHALL be XOR-reduction of push_data XOR EVEN_ODD, computed combinationally at push.
REQ-016 Stored word SHALL be {p, push_data} when SELECT_PARITY_BIT = 1, else {push_data, p}.
REQ-017 push_grant SHALL equal !full, combinational, independent of pop_grant.
REQ-018 Push SHALL occur when push_valid && push_grant: word written at write pointer, write pointer incremented.
REQ-019 pop_valid SHALL equal !empty; pop_data SHALL equal the entry at the read pointer, combinational from storage.
REQ-020 Pop SHALL occur when pop_valid && pop_grant: read pointer incremented; pop_grant while empty SHALL have no effect.
REQ-021 Pointers SHALL be $clog2(DEPTH)+1 bits with a wrap bit; full = (addr bits equal, wrap bits differ); empty = pointers equal.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0, toggling the wrap bit; no gap or duplicate entries across wrap.
REQ-023 Latency SHALL be 1 cycle: word pushed in cycle N is visible on pop_data and pop_valid in cycle N+1 when the FIFO was empty.
REQ-024 Simultaneous push and pop when neither full nor empty SHALL leave count unchanged and both pointers advanced.
REQ-025 When full, push_grant SHALL be 0 even if pop occurs the same cycle; the freed slot is grantable in the next cycle.
REQ-026 When empty, a push SHALL not pass through in the same cycle; pop_valid stays 0 that cycle.
REQ-027 count SHALL increment on push-only, decrement on pop-only, hold otherwise; never exceed DEPTH or go below 0.
REQ-028 pop_data SHALL hold stable while pop_valid = 1 and pop_grant = 0.
REQ-029 FIFO order SHALL be preserved; stored words SHALL NOT be modified after write.

Reset
REQ-030 While rst_n = 0 at a clk edge, pointers and count SHALL clear to 0; outputs empty = 1, full = 0, pop_valid = 0, push_grant = 1.
REQ-031 Storage contents SHALL NOT need reset; pop_data is don't-care while empty.
REQ-032 Reset asserted mid-operation SHALL discard all entries at that edge, overriding a simultaneous push or pop.

Verification
REQ-033 Bench SHALL cover reset: rst_n = 0 for 2 cycles with push_valid = 1 -> count = 0, empty = 1, pop_valid = 0, push_grant = 1.
REQ-034 Bench SHALL cover parity encoding at DATA_WIDTH = 8:
- EVEN_ODD = 0, LSB select, push 8'hA5 -> pop_data 9'h14A.
- EVEN_ODD = 1, LSB select, push 8'hA5 -> pop_data 9'h14B.
- EVEN_ODD = 0, MSB select, push 8'h01 -> pop_data 9'h101.
REQ-035 Bench SHALL cover fill at DEPTH = 8: push 8 words with pop_grant = 0 -> full = 1, count = 8, push_grant = 0; a 9th push_valid is not written.
REQ-036 Bench SHALL cover pop while full: pop from full with push_valid = 1 -> push_grant = 0 that cycle, 1 the next cycle; count goes 8 -> 7 -> 8.
REQ-037 Bench SHALL cover wrap: 20 words streamed with continuous push and pop -> output order equals input order, count stays at 1 after the first cycle.
REQ-038 Bench SHALL cover a downstream stall: pop_grant = 0 for 5 cycles with pop_valid = 1 -> pop_data unchanged, no entry lost.
